// File: rtl/program_sequencer_if.sv
// Command and status bundle between the control unit and the program sequencer.
// The shared data bus is a direct inout port of the sequencer, not part of this bundle.
interface program_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int SP_W = $clog2(DEPTH + 1);

    logic             ie;
    logic             oe;
    logic             step;
    logic             call;
    logic             ret;
    logic             clr_err;
    logic [WIDTH-1:0] pc;
    logic [SP_W-1:0]  sp;
    logic             full;
    logic             empty;
    logic             err;

    modport master (
        output ie, oe, step, call, ret, clr_err,
        input  pc, sp, full, empty, err
    );

    modport slave (
        input  ie, oe, step, call, ret, clr_err,
        output pc, sp, full, empty, err
    );
endinterface

// File: rtl/program_sequencer.sv
// Program counter with a hardware return stack, driving the shared tri-state bus.
// Supports jump, step, call and return with sticky overflow/underflow/illegal-command error.
module program_sequencer #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] RESET_ADDR = {WIDTH{1'b0}}
) (
    input  logic               clk,
    input  logic               rst_n,
    inout  wire  [WIDTH-1:0]   bus,
    program_sequencer_if.slave ctl
);
    localparam int               SP_W    = $clog2(DEPTH + 1);
    localparam logic [SP_W-1:0]  SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0]  SP_FULL = SP_W'(DEPTH);
    localparam logic [WIDTH-1:0] PC_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_nxt_s;
    logic [WIDTH-1:0] top_s;
    logic [SP_W-1:0]  sp_r;
    logic [SP_W-1:0]  sp_nxt_s;
    logic             err_r;
    logic             err_evt_s;
    logic             push_s;
    logic             full_s;
    logic             empty_s;
    logic             drive_ok_r;
    logic [3:0]       cmd_s;
    logic [WIDTH-1:0] stack_r [DEPTH];

    assign cmd_s   = {ctl.ie, ctl.step, ctl.call, ctl.ret};
    assign full_s  = (sp_r == SP_FULL);
    assign empty_s = (sp_r == {SP_W{1'b0}});

    // Top-of-stack read: entry sp-1, selected by compare because sp can equal DEPTH.
    always_comb begin
        top_s = {WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            top_s = (sp_r == SP_W'(i + 1)) ? stack_r[i] : top_s;
        end
    end

    // Command decode: any pattern that is not idle or a single command is illegal.
    always_comb begin
        pc_nxt_s  = pc_r;
        sp_nxt_s  = sp_r;
        push_s    = 1'b0;
        err_evt_s = 1'b0;
        case (cmd_s)
            4'b0000: begin
            end
            4'b1000: pc_nxt_s = bus;
            4'b0100: pc_nxt_s = pc_r + PC_ONE;
            4'b0010: begin
                if (full_s) begin
                    err_evt_s = 1'b1;
                end else begin
                    push_s   = 1'b1;
                    sp_nxt_s = sp_r + SP_ONE;
                    pc_nxt_s = bus;
                end
            end
            4'b0001: begin
                if (empty_s) begin
                    err_evt_s = 1'b1;
                end else begin
                    sp_nxt_s = sp_r - SP_ONE;
                    pc_nxt_s = top_s;
                end
            end
            default: err_evt_s = 1'b1;
        endcase
    end

    // PC, stack pointer, sticky error and stack storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r  <= RESET_ADDR;
            sp_r  <= {SP_W{1'b0}};
            err_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            pc_r  <= pc_nxt_s;
            sp_r  <= sp_nxt_s;
            err_r <= err_evt_s | (err_r & ~ctl.clr_err);
            for (int i = 0; i < DEPTH; i++) begin
                if (push_s && (sp_r == SP_W'(i))) begin
                    stack_r[i] <= pc_r;
                end
            end
        end
    end

    // Bus-drive permission: dropped asynchronously by reset, so the bus floats
    // while reset is held without routing rst_n into the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drive_ok_r <= 1'b0;
        end else begin
            drive_ok_r <= 1'b1;
        end
    end

    assign bus = (ctl.oe && drive_ok_r) ? pc_r : {WIDTH{1'bz}};

    assign ctl.pc    = pc_r;
    assign ctl.sp    = sp_r;
    assign ctl.full  = full_s;
    assign ctl.empty = empty_s;
    assign ctl.err   = err_r;
endmodule
